// File: rtl/io_responder_pkg.sv
// Shared widths, TX serialiser state type and byte-lane helper for the I/O responder.
package io_pkg;
    localparam int IO_WORD_W         = 32;
    localparam int IO_BYTE_W         = 8;
    localparam int IO_BYTES_PER_WORD = 4;
    localparam int IO_LANE_W         = $clog2(IO_BYTES_PER_WORD);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } io_tx_state_t;

    // Little-endian byte lane select: lane 0 is bits [7:0].
    function automatic logic [IO_BYTE_W-1:0] word_lane(
        input logic [IO_WORD_W-1:0] word,
        input logic [IO_LANE_W-1:0] lane
    );
        logic [IO_BYTE_W-1:0] result;
        case (lane)
            2'd0:    result = word[7:0];
            2'd1:    result = word[15:8];
            2'd2:    result = word[23:16];
            2'd3:    result = word[31:24];
            default: result = {IO_BYTE_W{1'b0}};
        endcase
        return result;
    endfunction
endpackage

// File: rtl/io_responder_if.sv
// Core-side word handshake and UART-side byte signals of io_responder.
// With IO_STATS_EN defined the bundle also carries tx_word_count / rx_word_count.
interface io_responder_if;
    import io_pkg::*;

    logic                 out_issued;
    logic [IO_WORD_W-1:0] out_data;
    logic                 out_stall;
    logic                 in_issued;
    logic [IO_WORD_W-1:0] in_data;
    logic                 in_stall;
    logic [IO_BYTE_W-1:0] tx_byte;
    logic                 tx_byte_valid;
    logic                 tx_byte_ready;
    logic [IO_BYTE_W-1:0] rx_byte;
    logic                 rx_byte_valid;
    logic                 rx_overrun;
`ifdef IO_STATS_EN
    logic [31:0]          tx_word_count;
    logic [31:0]          rx_word_count;
`endif

    modport slave (
        input  out_issued, out_data, in_issued, tx_byte_ready, rx_byte, rx_byte_valid,
        output out_stall, in_data, in_stall, tx_byte, tx_byte_valid, rx_overrun
`ifdef IO_STATS_EN
        , output tx_word_count, rx_word_count
`endif
    );

    modport master (
        output out_issued, out_data, in_issued, tx_byte_ready, rx_byte, rx_byte_valid,
        input  out_stall, in_data, in_stall, tx_byte, tx_byte_valid, rx_overrun
`ifdef IO_STATS_EN
        , input tx_word_count, rx_word_count
`endif
    );
endinterface

// File: rtl/io_responder_fifo.sv
// Show-ahead word FIFO with wrap-bit pointers; dout reads 0 while empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module io_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and qualified push/pop strobes.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (empty) begin
            dout = {WIDTH{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/io_responder.sv
// Responder end of the core's word I/O port: TX word FIFO feeding a byte serialiser,
// RX byte assembler feeding a word FIFO. Optional macro IO_STATS_EN adds word counters.
module io_responder
    import io_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    io_responder_if.slave io
);
    localparam logic [IO_LANE_W-1:0] LANE_ZERO = {IO_LANE_W{1'b0}};
    localparam logic [IO_LANE_W-1:0] LANE_ONE  = IO_LANE_W'(1);
    localparam logic [IO_LANE_W-1:0] LANE_LAST = IO_LANE_W'(IO_BYTES_PER_WORD - 1);

    logic                 tx_push_s;
    logic                 tx_pop_s;
    logic                 tx_full_s;
    logic                 tx_empty_s;
    logic [IO_WORD_W-1:0] tx_dout_s;

    io_tx_state_t         tx_state_r;
    io_tx_state_t         tx_state_s;
    logic [IO_WORD_W-1:0] tx_hold_r;
    logic [IO_WORD_W-1:0] tx_hold_s;
    logic [IO_LANE_W-1:0] tx_idx_r;
    logic [IO_LANE_W-1:0] tx_idx_s;
    logic [IO_BYTE_W-1:0] tx_byte_r;
    logic [IO_BYTE_W-1:0] tx_byte_s;
    logic                 tx_valid_r;
    logic                 tx_valid_s;

    logic [IO_LANE_W-1:0]           rx_idx_r;
    logic [IO_WORD_W-IO_BYTE_W-1:0] rx_asm_r;
    logic [IO_WORD_W-1:0]           rx_word_s;
    logic [IO_WORD_W-1:0]           rx_dout_s;
    logic                           rx_last_s;
    logic                           rx_push_s;
    logic                           rx_pop_s;
    logic                           rx_drop_s;
    logic                           rx_full_s;
    logic                           rx_empty_s;
    logic                           rx_overrun_r;

    // Core-facing handshakes; out_stall deliberately ignores a same-cycle TX pop.
    always_comb begin
        tx_push_s = io.out_issued & ~tx_full_s;
        rx_pop_s  = io.in_issued & ~rx_empty_s;
    end

    assign io.out_stall     = io.out_issued & tx_full_s;
    assign io.in_stall      = io.in_issued & rx_empty_s;
    assign io.in_data       = rx_dout_s;
    assign io.tx_byte       = tx_byte_r;
    assign io.tx_byte_valid = tx_valid_r;
    assign io.rx_overrun    = rx_overrun_r;

    io_fifo #(
        .WIDTH (IO_WORD_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (io.out_data),
        .dout  (tx_dout_s),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    // Serialiser next state; the output byte is precomputed so tx_byte is a plain register.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_hold_s  = tx_hold_r;
        tx_idx_s   = tx_idx_r;
        tx_pop_s   = 1'b0;
        tx_byte_s  = {IO_BYTE_W{1'b0}};
        tx_valid_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_hold_s  = tx_dout_s;
                    tx_idx_s   = LANE_ZERO;
                    tx_state_s = TX_SEND;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (io.tx_byte_ready) begin
                    if (tx_idx_r == LANE_LAST) begin
                        tx_idx_s = LANE_ZERO;
                        if (!tx_empty_s) begin
                            // Chain straight into the next word without an idle bubble.
                            tx_pop_s   = 1'b1;
                            tx_hold_s  = tx_dout_s;
                            tx_state_s = TX_SEND;
                        end else begin
                            tx_state_s = TX_IDLE;
                        end
                    end else begin
                        tx_idx_s = tx_idx_r + LANE_ONE;
                    end
                end else begin
                    tx_state_s = TX_SEND;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_idx_s   = LANE_ZERO;
            end
        endcase
        if (tx_state_s == TX_SEND) begin
            tx_valid_s = 1'b1;
            tx_byte_s  = word_lane(tx_hold_s, tx_idx_s);
        end else begin
            tx_valid_s = 1'b0;
            tx_byte_s  = {IO_BYTE_W{1'b0}};
        end
    end

    // Serialiser state and registered byte outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_hold_r  <= {IO_WORD_W{1'b0}};
            tx_idx_r   <= LANE_ZERO;
            tx_byte_r  <= {IO_BYTE_W{1'b0}};
            tx_valid_r <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_hold_r  <= tx_hold_s;
            tx_idx_r   <= tx_idx_s;
            tx_byte_r  <= tx_byte_s;
            tx_valid_r <= tx_valid_s;
        end
    end

    // Word completion; a full RX FIFO drops the word unless it is popped this cycle.
    always_comb begin
        rx_word_s = {io.rx_byte, rx_asm_r};
        rx_last_s = io.rx_byte_valid & (rx_idx_r == LANE_LAST);
        rx_push_s = rx_last_s & (~rx_full_s | rx_pop_s);
        rx_drop_s = rx_last_s & rx_full_s & ~rx_pop_s;
    end

    // Byte assembly into lanes 0..2; lane 3 goes straight to the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_idx_r <= LANE_ZERO;
            rx_asm_r <= {(IO_WORD_W-IO_BYTE_W){1'b0}};
        end else if (io.rx_byte_valid) begin
            case (rx_idx_r)
                2'd0:    rx_asm_r[7:0]   <= io.rx_byte;
                2'd1:    rx_asm_r[15:8]  <= io.rx_byte;
                2'd2:    rx_asm_r[23:16] <= io.rx_byte;
                default: rx_asm_r        <= rx_asm_r;
            endcase
            rx_idx_r <= rx_idx_r + LANE_ONE;
        end
    end

    // Sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun_r <= 1'b0;
        end else if (rx_drop_s) begin
            rx_overrun_r <= 1'b1;
        end
    end

    io_fifo #(
        .WIDTH (IO_WORD_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .din   (rx_word_s),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

`ifdef IO_STATS_EN
    logic [31:0] tx_word_count_r;
    logic [31:0] rx_word_count_r;

    // Word counters; dropped RX words are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_word_count_r <= 32'd0;
            rx_word_count_r <= 32'd0;
        end else begin
            if (tx_push_s) begin
                tx_word_count_r <= tx_word_count_r + 32'd1;
            end
            if (rx_push_s) begin
                rx_word_count_r <= rx_word_count_r + 32'd1;
            end
        end
    end

    assign io.tx_word_count = tx_word_count_r;
    assign io.rx_word_count = rx_word_count_r;
`endif
endmodule
